// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: EX-stage multiply/divide sequencer that owns HI/LO.
// Multiplies finish in one MUL cycle from latched operands. Divides run
// a 32-step restoring divider on magnitudes, then a FIX cycle restores
// the signs. Divide-by-zero skips straight to FIX. MTHI/MTLO write in
// IDLE without stalling.
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Two's-complement negate of a 32-bit value.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Negate v when en is set, otherwise pass it through.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en) begin
            r = neg32(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Magnitude of v for a signed op. Unsigned ops pass v through unchanged.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return cond_neg32(v, is_signed & v[31]);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opa_q, opa_d;     // multiplicand, or raw dividend for divide-by-zero
    logic [31:0] opb_q, opb_d;     // multiplier, or divisor magnitude
    logic        msign_q, msign_d; // signed multiply
    logic [31:0] rem_q, rem_d;     // partial remainder
    logic [31:0] quot_q, quot_d;   // dividend bits shifting out, quotient bits shifting in
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;   // quotient must be negated
    logic        rneg_q, rneg_d;   // remainder must be negated
    logic        zdiv_q, zdiv_d;   // divisor was zero
    logic        busy_q;

    logic        start_ok_s;
    logic        is_muldiv_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;
    logic [32:0] shifted_s, trial_s;

    // Decode the incoming op and build the multiply and divide-step datapath.
    always_comb begin
        start_ok_s  = op_valid_i & ~flush_i;
        is_muldiv_s = (op_i == OP_MULT) | (op_i == OP_MULTU) |
                      (op_i == OP_DIV)  | (op_i == OP_DIVU);
        mul_a_s     = {{32{msign_q & opa_q[31]}}, opa_q};
        mul_b_s     = {{32{msign_q & opb_q[31]}}, opb_q};
        prod_s      = mul_a_s * mul_b_s;
        shifted_s   = {rem_q, quot_q[31]};
        trial_s     = shifted_s - {1'b0, opb_q};
    end

    // Compute the next state and the next HI/LO and working registers.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        msign_d = msign_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zdiv_d  = zdiv_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            opa_d   = a_i;
                            opb_d   = b_i;
                            msign_d = (op_i == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_d = a_i;
                            if (b_i == 32'd0) begin
                                state_d = ST_FIX;
                                zdiv_d  = 1'b1;
                            end else begin
                                state_d = ST_DIV;
                                zdiv_d  = 1'b0;
                                quot_d  = mag32(a_i, op_i == OP_DIV);
                                opb_d   = mag32(b_i, op_i == OP_DIV);
                                rem_d   = 32'd0;
                                cnt_d   = 5'd0;
                                qneg_d  = (op_i == OP_DIV) & (a_i[31] ^ b_i[31]);
                                rneg_d  = (op_i == OP_DIV) & a_i[31];
                            end
                        end
                        OP_MTHI: begin
                            hi_d = a_i;
                        end
                        OP_MTLO: begin
                            lo_d = a_i;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = prod_s[63:32];
                    lo_d    = prod_s[31:0];
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    // A set sign bit means the trial subtraction went negative.
                    if (trial_s[32]) begin
                        rem_d  = shifted_s[31:0];
                        quot_d = {quot_q[30:0], 1'b0};
                    end else begin
                        rem_d  = trial_s[31:0];
                        quot_d = {quot_q[30:0], 1'b1};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (zdiv_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = opa_q;
                    end else begin
                        lo_d = cond_neg32(quot_q, qneg_q);
                        hi_d = cond_neg32(rem_q, rneg_q);
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The producing instruction is still held valid this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, HI/LO and working registers. Reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            msign_q <= 1'b0;
            rem_q   <= 32'd0;
            quot_q  <= 32'd0;
            cnt_q   <= 5'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            msign_q <= msign_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zdiv_q  <= zdiv_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Stall covers the issue cycle of a mul/div and every in-flight cycle.
    // It drops for a flush and is forced low while reset is asserted.
    always_comb begin
        stall_o = rst & ~flush_i &
                  (((state_q == ST_IDLE) & op_valid_i & is_muldiv_s) |
                   (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX));
    end

    assign busy_o = busy_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl. Expected HI:LO results go into a
// scoreboard queue when an op is issued and are compared when the DUT reaches DONE.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    hilo_muldiv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid_i (op_valid_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    // Issue one mul/div and hold it valid while stalled and through DONE.
    // Count the stall cycles, then check HI:LO against the scoreboard.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall, input logic [63:0] exp);
        int n;
        logic [63:0] e;
        @(negedge clk);
        op_valid_i = 1'b1; op_i = op; a_i = a; b_i = b; flush_i = 1'b0;
        exp_q.push_back(exp);
        n = 0;
        #1;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, n, exp_stall);
        end
        e = exp_q.pop_front();
        checks++;
        if ({hi_o, lo_o} !== e) begin
            errors++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", name, hi_o, lo_o, e[63:32], e[31:0]);
        end
        @(negedge clk);
        op_valid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL %s no_reissue: got busy=%b stall=%b expected 0 0", name, busy_o, stall_o);
        end
    endtask

    // Preload HI and LO with two moves so later checks can detect writes.
    task automatic preload(input logic [31:0] hv, input logic [31:0] lv);
        @(negedge clk);
        op_valid_i = 1'b1; op_i = OP_MTHI; a_i = hv; flush_i = 1'b0;
        @(negedge clk);
        op_i = OP_MTLO; a_i = lv;
        @(negedge clk);
        op_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; op_valid_i = 1'b1; op_i = OP_MULT; a_i = 32'd3; b_i = 32'd4; flush_i = 1'b0;
        #3;
        checks++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b busy=%b hi=%h lo=%h expected all 0",
                     stall_o, busy_o, hi_o, lo_o);
        end
        op_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mul();
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5, 2, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu",     OP_MULTU, 32'hFFFF_FFFD, 32'd5, 2, 64'h0000_0004_FFFF_FFF1);
        run_op("mult_big",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 2, 64'h4000_0000_0000_0000);
    endtask

    task automatic test_div();
        run_op("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 34, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_negb",  OP_DIV,  32'd7, 32'hFFFF_FFFE, 34, 64'h0000_0001_FFFF_FFFD);
        run_op("divu",      OP_DIVU, 32'hFFFF_FFFF, 32'h10, 34, 64'h0000_000F_0FFF_FFFF);
        run_op("div_wrap",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 34, 64'h0000_0000_8000_0000);
    endtask

    task automatic test_divzero();
        run_op("div_zero",  OP_DIV,  32'h1234, 32'd0, 2, 64'h0000_1234_FFFF_FFFF);
        run_op("divu_zero", OP_DIVU, 32'h8000_0001, 32'd0, 2, 64'h8000_0001_FFFF_FFFF);
    endtask

    // Flush a divide after 'at' cycles. at=11 hits counter 10, at=33 hits FIX.
    task automatic flush_div(input string name, input int at);
        preload(32'hAAAA_AAAA, 32'h5555_5555);
        @(negedge clk);
        op_valid_i = 1'b1; op_i = OP_DIV; a_i = 32'hFFFF_FFF9; b_i = 32'd2;
        repeat (at) @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s in_flight: got stall=%b busy=%b expected 1 1", name, stall_o, busy_o);
        end
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL %s flush_stall: got %b expected 0", name, stall_o);
        end
        @(negedge clk);
        flush_i = 1'b0; op_valid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || hi_o !== 32'hAAAA_AAAA || lo_o !== 32'h5555_5555) begin
            errors++;
            $display("FAIL %s after_flush: got busy=%b hi=%h lo=%h expected 0 aaaaaaaa 55555555",
                     name, busy_o, hi_o, lo_o);
        end
    endtask

    task automatic test_flush();
        flush_div("flush_div10", 11);
        flush_div("flush_fix", 33);
        // Flush in IDLE: the move is dropped and the multiply never starts.
        @(negedge clk);
        op_valid_i = 1'b1; op_i = OP_MTHI; a_i = 32'h99; flush_i = 1'b1;
        @(negedge clk);
        op_i = OP_MULT; a_i = 32'd2; b_i = 32'd3;
        #1;
        checks++;
        if (stall_o !== 1'b0 || hi_o !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL flush_idle_move: got stall=%b hi=%h expected 0 aaaaaaaa", stall_o, hi_o);
        end
        @(negedge clk);
        op_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || lo_o !== 32'h5555_5555) begin
            errors++;
            $display("FAIL flush_idle_start: got busy=%b lo=%h expected 0 55555555", busy_o, lo_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op_valid_i = 1'b1; op_i = OP_MTHI; a_i = 32'h11; flush_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL mthi_stall: got %b expected 0", stall_o);
        end
        @(negedge clk);
        checks++;
        if (hi_o !== 32'h11 || lo_o !== 32'h5555_5555) begin
            errors++;
            $display("FAIL mthi_value: got hi=%h lo=%h expected 00000011 55555555", hi_o, lo_o);
        end
        op_i = OP_MTLO; a_i = 32'h22;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_stall: got %b expected 0", stall_o);
        end
        @(negedge clk);
        op_valid_i = 1'b0;
        checks++;
        if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
            errors++;
            $display("FAIL mtlo_value: got hi=%h lo=%h expected 00000011 00000022", hi_o, lo_o);
        end
        run_op("mult_after_moves", OP_MULT, 32'd7, 32'hFFFF_FFFE, 2, 64'hFFFF_FFFF_FFFF_FFF2);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        op_valid_i = 1'b1; op_i = OP_DIV; a_i = 32'h1000; b_i = 32'd3; flush_i = 1'b0;
        repeat (21) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b busy=%b hi=%h lo=%h expected all 0",
                     stall_o, busy_o, hi_o, lo_o);
        end
        @(negedge clk);
        op_valid_i = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        run_op("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 34, 64'h0000_0002_0000_000E);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_divzero();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
